cache_set_assoc: RTL and testbench
==================================

Name: cache_set_assoc

Overview:
- Parametrised N-way set-associative cache data/tag store; successor to the single-line cache store.
- Holds SETS x WAYS lines of WORDS words, with per-line valid/dirty and per-set LRU replacement.
- Sits between the CPU memory stage and the cache controller FSM. The controller drives load (refill), edit (store), and invalid. It reads hit/valid/dirty/tag to decide on writeback.

Parameters:
- ADDR_W, 32, address width in bits (byte address).
- WORDS, 8, 32-bit words per line; power of 2, 2..16.
- SETS, 32, number of sets; power of 2, 2..256.
- WAYS, 2, associativity; one of 1, 2, 4.
- Derived values:
  - OFF_W = log2(WORDS)
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_W - IDX_W - OFF_W - 2 (22 at defaults)
  - WAY_W = max(1, log2(WAYS))

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, synchronous active-low reset.
- addr, input, ADDR_W, byte address. Field layout:
  - word offset = addr[OFF_W+1:2]
  - set index = addr[IDX_W+OFF_W+1:OFF_W+2]
  - tag = upper TAG_W bits
- load, input, 1, refill write of din into the addressed word.
- edit, input, 1, store write of din into the addressed word; only on hit.
- invalid, input, 1, invalidate the addressed line; only on hit.
- din, input, 32, write data.
- hit, output, 1, combinational: a valid way in the indexed set matches the tag.
- way, output, WAY_W, selected way: the hit way if hit, else the victim way.
- valid, output, 1, valid bit of the selected way.
- dirty, output, 1, dirty bit of the selected way.
- tag, output, TAG_W, stored tag of the selected way; 0 when that way is invalid.
- dout, output, 32, addressed word of the hit way; 0 on miss.

Behaviour:
- Lookup:
  - Fully combinational from addr and current state; zero latency.
  - Writes become visible on the outputs in the cycle after the edge.
- Victim selection on miss:
  - First choice: the lowest-index invalid way.
  - Otherwise: the way with the maximum LRU age.
- Priority when strobes coincide: invalid > load > edit. Only one operation takes effect per edge.
- load:
  - Target way = hit way if hit, else victim.
  - Write din to the target word; stored tag = addr tag; valid = 1, dirty = 0.
  - Consecutive loads to the same line therefore fill the same way.
- edit:
  - On hit: write din, dirty = 1.
  - On miss: no state change of any kind, including LRU.
- invalid:
  - On hit: valid = 0, dirty = 0; data and tag are retained; LRU is unchanged.
  - On miss: no-op.
- LRU:
  - One WAY_W-bit age per way per set.
  - Updated on load (any) and on edit hit.
  - Accessed way's age is set to 0. Ways whose age was below the accessed way's old age increment by 1. Other ages are unchanged.
  - Ages in a set stay a permutation of 0..WAYS-1.
  - WAYS = 1: LRU logic degenerates; way is always 0.
- Reset (rst = 0 at a rising edge):
  - All valid and dirty bits cleared.
  - Age of way w in every set = w, so the first victim is the lowest invalid way.
  - Data and tag arrays are not cleared.
  - Post-reset outputs: hit = 0, valid = 0, dirty = 0, tag = 0, dout = 0, way = 0.
  - Reset overrides any simultaneous load/edit/invalid. Reset asserted during a multi-cycle refill discards the partial line.
- Writes are 32-bit words only; addr[1:0] is ignored.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Each edge with (load|edit) and no invalid increments hit_cnt if hit, else miss_cnt.
  - Counters saturate at 32'hFFFFFFFF and are cleared by rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Refill: after reset, load = 1, din = 32'h11111111, addr = 0x00, then 0x04 → after the first edge hit = 1, way = 0, valid = 1, dirty = 0, tag = 0, dout = 32'h11111111. With stats: miss_cnt = 1, hit_cnt = 1.
- Store hit: edit = 1, din = 32'h22222222, addr = 0x08 → dout = 32'h22222222, dirty = 1; word 0x04 still reads 32'h11111111.
- Store miss: edit = 1, addr = 0x800 with set 0 full of other tags → hit = 0; no array, valid, dirty, or LRU change; dout = 0.
- Eviction (defaults):
  - Load 0x000, then 0x400 (same set 0, tags 0 and 1), then edit 0x000.
  - Present addr = 0x800 → hit = 0, way = 1 (tag 1 is LRU), valid = 1, dirty = 0, tag = 1.
  - Load 0x800 → way 1 now holds tag 2, dirty = 0; way 0 still tag 0, dirty = 1.
- Invalidate: invalid = 1, addr = 0x000 → next cycle hit = 0, way = 0, valid = 0, dirty = 0. load + invalid in the same cycle at addr 0x800 → only the invalidate occurs.
- Reset mid-refill: load 0x0A8, rst = 0 for one edge while load = 1 → all outputs 0; addr = 0x0A8 then misses.

Source files
------------

// File: rtl/cache_set_assoc_if.sv
// Lookup/update bus between the controller and the set-associative cache store.
// Latency: none of its own; it only carries signals.
// Backpressure: none; the store accepts a strobe every cycle.
//
// Signals (master = controller, slave = cache store):
//   addr    byte address (word offset, set index and tag fields)
//   load    refill write of din into the addressed word
//   edit    store write of din into the addressed word (hit only)
//   invalid invalidate the addressed line (hit only)
//   din     write data
//   hit     a valid way in the indexed set matches the tag
//   way     hit way on hit, victim way on miss
//   valid   valid bit of the selected way
//   dirty   dirty bit of the selected way
//   tag     stored tag of the selected way, 0 when that way is invalid
//   dout    addressed word of the hit way, 0 on miss
//   hit_cnt/miss_cnt  access counters, present only with CACHE_STATS_EN
interface cache_set_assoc_if #(
    parameter int ADDR_W = 32,
    parameter int WORDS  = 8,
    parameter int SETS   = 32,
    parameter int WAYS   = 2
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [ADDR_W-1:0] addr;
    logic              load;
    logic              edit;
    logic              invalid;
    logic [31:0]       din;

    logic              hit;
    logic [WAY_W-1:0]  way;
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [31:0]       dout;

`ifdef CACHE_STATS_EN
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    modport master (
        output addr, load, edit, invalid, din,
        input  hit, way, valid, dirty, tag, dout, hit_cnt, miss_cnt
    );

    modport slave (
        input  addr, load, edit, invalid, din,
        output hit, way, valid, dirty, tag, dout, hit_cnt, miss_cnt
    );
`else
    modport master (
        output addr, load, edit, invalid, din,
        input  hit, way, valid, dirty, tag, dout
    );

    modport slave (
        input  addr, load, edit, invalid, din,
        output hit, way, valid, dirty, tag, dout
    );
`endif

endinterface

// File: rtl/cache_set_assoc.sv
// N-way set-associative cache data/tag store with per-line valid/dirty and per-set LRU ages.
// Latency: lookup is combinational (zero cycles); writes show on the outputs the cycle after the edge.
// Backpressure: none; one operation is accepted every cycle (invalid > load > edit).
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous active-low reset (clears valid/dirty, restores ages; data/tag kept)
//   bus   cache_set_assoc_if.slave: addr/load/edit/invalid/din in, hit/way/valid/dirty/tag/dout out
// Optional: define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt counters on the bus.
// The interface instance must be built with the same ADDR_W/WORDS/SETS/WAYS as this module.
module cache_set_assoc #(
    parameter int ADDR_W = 32,
    parameter int WORDS  = 8,
    parameter int SETS   = 32,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    cache_set_assoc_if.slave  bus
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    // ---------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------
    logic [31:0]      data_q  [SETS][WAYS][WORDS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAY_W-1:0] age_q   [SETS][WAYS];

    // ---------------------------------------------------------------
    // Address fields
    // ---------------------------------------------------------------
    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] atag;
    logic             unused_addr_bits;

    assign off  = bus.addr[OFF_W+1:2];
    assign idx  = bus.addr[IDX_W+OFF_W+1:OFF_W+2];
    assign atag = bus.addr[ADDR_W-1:ADDR_W-TAG_W];
    // Byte lane bits play no part: all accesses are whole words.
    assign unused_addr_bits = &{1'b0, bus.addr[1:0]};

    // ---------------------------------------------------------------
    // Tag match
    // ---------------------------------------------------------------
    logic             hit_c;
    logic [WAY_W-1:0] hit_way;

    always_comb begin
        hit_c   = 1'b0;
        hit_way = '0;
        // Walk downwards so the lowest matching way wins if tags were ever duplicated.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == atag)) begin
                hit_c   = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // ---------------------------------------------------------------
    // Victim selection: lowest invalid way, else the oldest way
    // ---------------------------------------------------------------
    logic             found_inv;
    logic [WAY_W-1:0] victim;

    always_comb begin
        found_inv = 1'b0;
        victim    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_inv && !valid_q[idx][w]) begin
                found_inv = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        // Ages are a permutation of 0..WAYS-1, so the maximum is exactly WAYS-1.
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == WAY_W'(WAYS - 1)) begin
                    victim = WAY_W'(w);
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Selected way and outputs
    // ---------------------------------------------------------------
    logic [WAY_W-1:0] sel_way;
    logic             sel_valid;

    assign sel_way   = hit_c ? hit_way : victim;
    assign sel_valid = valid_q[idx][sel_way];

    assign bus.hit   = hit_c;
    assign bus.way   = sel_way;
    assign bus.valid = sel_valid;
    assign bus.dirty = dirty_q[idx][sel_way];
    assign bus.tag   = sel_valid ? tag_q[idx][sel_way] : '0;
    assign bus.dout  = hit_c ? data_q[idx][hit_way][off] : '0;

    // ---------------------------------------------------------------
    // Operation decode: only the highest-priority strobe acts
    // ---------------------------------------------------------------
    logic do_inv;
    logic do_load;
    logic do_edit;
    logic do_wr;

    assign do_inv  = bus.invalid & hit_c;
    assign do_load = bus.load & ~bus.invalid;
    assign do_edit = bus.edit & ~bus.load & ~bus.invalid & hit_c;
    assign do_wr   = do_load | do_edit;

    // ---------------------------------------------------------------
    // LRU age update for the accessed way
    // ---------------------------------------------------------------
    logic [WAY_W-1:0] old_age;
    logic [WAY_W-1:0] age_next [WAYS];

    always_comb begin
        old_age = age_q[idx][sel_way];
        for (int w = 0; w < WAYS; w++) begin
            age_next[w] = age_q[idx][w];
            if (WAY_W'(w) == sel_way) begin
                age_next[w] = '0;
            end else if (age_q[idx][w] < old_age) begin
                age_next[w] = age_q[idx][w] + WAY_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Data and tag arrays: never cleared, but reset still blocks writes
    // so a refill interrupted by reset leaves no trace.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst && do_wr) begin
            data_q[idx][sel_way][off] <= bus.din;
        end
        if (rst && do_load) begin
            tag_q[idx][sel_way] <= atag;
        end
    end

    // ---------------------------------------------------------------
    // Valid / dirty / age state
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            if (do_inv) begin
                valid_q[idx][sel_way] <= 1'b0;
                dirty_q[idx][sel_way] <= 1'b0;
            end else if (do_load) begin
                valid_q[idx][sel_way] <= 1'b1;
                dirty_q[idx][sel_way] <= 1'b0;
            end else if (do_edit) begin
                dirty_q[idx][sel_way] <= 1'b1;
            end
            if (do_wr) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[idx][w] <= age_next[w];
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    // ---------------------------------------------------------------
    // Saturating access counters
    // ---------------------------------------------------------------
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if ((bus.load | bus.edit) & ~bus.invalid) begin
            if (hit_c) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_set_assoc.sv
// Bench for cache_set_assoc at default parameters (32-bit address, 8 words, 32 sets, 2 ways).
// Latency: vectors are driven just after a rising edge and checked on the following falling edge.
// Backpressure: none; one vector per cycle.
module tb_cache_set_assoc;

    logic clk;
    logic rst;

    cache_set_assoc_if #(.ADDR_W(32), .WORDS(8), .SETS(32), .WAYS(2)) bus ();

    cache_set_assoc #(.ADDR_W(32), .WORDS(8), .SETS(32), .WAYS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: inputs, then the outputs expected during that
    // cycle (before the edge that applies the strobes).
    typedef struct {
        string       name;
        bit          rstn;
        logic [31:0] addr;
        bit          load;
        bit          edit;
        bit          inv;
        logic [31:0] din;
        bit          e_hit;
        logic [0:0]  e_way;
        bit          e_valid;
        bit          e_dirty;
        logic [21:0] e_tag;
        logic [31:0] e_dout;
        bit          dc_dout;   // word never written: contents undefined
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];

    int nerr = 0;
    int nchk = 0;

`ifdef CACHE_STATS_EN
    logic [31:0] exp_hc = 0;
    logic [31:0] exp_mc = 0;
`endif

    function automatic vec_t mk(string n, bit r, logic [31:0] a, bit l, bit e, bit i,
                                logic [31:0] d, bit h, int w, bit v, bit dy, int t,
                                logic [31:0] o, bit dc);
        vec_t x;
        x.name = n;  x.rstn = r;  x.addr = a;  x.load = l;  x.edit = e;  x.inv = i;
        x.din = d;   x.e_hit = h; x.e_way = 1'(w); x.e_valid = v; x.e_dirty = dy;
        x.e_tag = 22'(t); x.e_dout = o; x.dc_dout = dc;
        return x;
    endfunction

    // Scoreboard consumer: compare DUT outputs against the queued expectation.
    always @(negedge clk) begin
        vec_t        x;
        logic [31:0] act_dout;
        logic [31:0] exp_dout;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            act_dout = x.dc_dout ? 32'h0 : bus.dout;
            exp_dout = x.dc_dout ? 32'h0 : x.e_dout;
            nchk++;
            if (bus.hit !== x.e_hit || bus.way !== x.e_way || bus.valid !== x.e_valid ||
                bus.dirty !== x.e_dirty || bus.tag !== x.e_tag || act_dout !== exp_dout) begin
                nerr++;
                $display("FAIL %s: got hit=%0b way=%0d valid=%0b dirty=%0b tag=%h dout=%h, want hit=%0b way=%0d valid=%0b dirty=%0b tag=%h dout=%h%s",
                         x.name, bus.hit, bus.way, bus.valid, bus.dirty, bus.tag, bus.dout,
                         x.e_hit, x.e_way, x.e_valid, x.e_dirty, x.e_tag, x.e_dout,
                         x.dc_dout ? " (dout ignored)" : "");
            end
`ifdef CACHE_STATS_EN
            nchk++;
            if (bus.hit_cnt !== exp_hc || bus.miss_cnt !== exp_mc) begin
                nerr++;
                $display("FAIL stats_%s: got hit_cnt=%0d miss_cnt=%0d, want hit_cnt=%0d miss_cnt=%0d",
                         x.name, bus.hit_cnt, bus.miss_cnt, exp_hc, exp_mc);
            end
            if (!x.rstn) begin
                exp_hc = 0;
                exp_mc = 0;
            end else if ((x.load || x.edit) && !x.inv) begin
                if (x.e_hit) exp_hc++;
                else         exp_mc++;
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d, want 0", sb.size());
        $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        //            name                   rst addr     ld ed iv din           hit way v  d  tag dout          dc
        vt.push_back(mk("reset_state",         1, 32'h000, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0));
        vt.push_back(mk("refill_miss_000",     1, 32'h000, 1, 0, 0, 32'h11111111, 0, 0, 0, 0, 0, 32'h0,        0));
        vt.push_back(mk("refill_hit_000",      1, 32'h000, 0, 0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h11111111, 0));
        vt.push_back(mk("refill_004",          1, 32'h004, 1, 0, 0, 32'h11111111, 1, 0, 1, 0, 0, 32'h0,        1));
        vt.push_back(mk("store_hit_008",       1, 32'h008, 0, 1, 0, 32'h22222222, 1, 0, 1, 0, 0, 32'h0,        1));
        vt.push_back(mk("store_read_008",      1, 32'h008, 0, 0, 0, 32'h0,        1, 0, 1, 1, 0, 32'h22222222, 0));
        vt.push_back(mk("word_004_kept",       1, 32'h004, 0, 0, 0, 32'h0,        1, 0, 1, 1, 0, 32'h11111111, 0));
        vt.push_back(mk("fill_way1_400",       1, 32'h400, 1, 0, 0, 32'h33333333, 0, 1, 0, 0, 0, 32'h0,        0));
        vt.push_back(mk("read_way1_400",       1, 32'h400, 0, 0, 0, 32'h0,        1, 1, 1, 0, 1, 32'h33333333, 0));
        vt.push_back(mk("edit_000",            1, 32'h000, 0, 1, 0, 32'h44444444, 1, 0, 1, 1, 0, 32'h11111111, 0));
        vt.push_back(mk("store_miss_800",      1, 32'h800, 0, 1, 0, 32'hDEADBEEF, 0, 1, 1, 0, 1, 32'h0,        0));
        vt.push_back(mk("victim_800",          1, 32'h800, 0, 0, 0, 32'h0,        0, 1, 1, 0, 1, 32'h0,        0));
        vt.push_back(mk("after_miss_000",      1, 32'h000, 0, 0, 0, 32'h0,        1, 0, 1, 1, 0, 32'h44444444, 0));
        vt.push_back(mk("after_miss_400",      1, 32'h400, 0, 0, 0, 32'h0,        1, 1, 1, 0, 1, 32'h33333333, 0));
        vt.push_back(mk("evict_load_800",      1, 32'h800, 1, 0, 0, 32'h55555555, 0, 1, 1, 0, 1, 32'h0,        0));
        vt.push_back(mk("evicted_read_800",    1, 32'h800, 0, 0, 0, 32'h0,        1, 1, 1, 0, 2, 32'h55555555, 0));
        vt.push_back(mk("kept_way0_000",       1, 32'h000, 0, 0, 0, 32'h0,        1, 0, 1, 1, 0, 32'h44444444, 0));
        vt.push_back(mk("gone_400",            1, 32'h400, 0, 0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        0));
        vt.push_back(mk("inval_000",           1, 32'h000, 0, 0, 1, 32'h0,        1, 0, 1, 1, 0, 32'h44444444, 0));
        vt.push_back(mk("inval_read_000",      1, 32'h000, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0));
        vt.push_back(mk("load_inval_800",      1, 32'h800, 1, 0, 1, 32'h66666666, 1, 1, 1, 0, 2, 32'h55555555, 0));
        vt.push_back(mk("only_inval_800",      1, 32'h800, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0));
        vt.push_back(mk("fill_set5_0a8",       1, 32'h0A8, 1, 0, 0, 32'h77777777, 0, 0, 0, 0, 0, 32'h0,        0));
        vt.push_back(mk("read_set5_0a8",       1, 32'h0A8, 0, 0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h77777777, 0));
        vt.push_back(mk("rst_mid_refill_0ac",  0, 32'h0AC, 1, 0, 0, 32'h88888888, 1, 0, 1, 0, 0, 32'h0,        1));
        vt.push_back(mk("after_rst_0a8",       1, 32'h0A8, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0));
        vt.push_back(mk("after_rst_0ac",       1, 32'h0AC, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0));
        vt.push_back(mk("after_rst_000",       1, 32'h000, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0));
        vt.push_back(mk("load_again_000",      1, 32'h000, 1, 0, 0, 32'h99999999, 0, 0, 0, 0, 0, 32'h0,        0));
        vt.push_back(mk("load_edit_004",       1, 32'h004, 1, 1, 0, 32'hAAAAAAAA, 1, 0, 1, 0, 0, 32'h0,        1));
        vt.push_back(mk("load_won_004",        1, 32'h004, 0, 0, 0, 32'h0,        1, 0, 1, 0, 0, 32'hAAAAAAAA, 0));
        vt.push_back(mk("edit_inval_000",      1, 32'h000, 0, 1, 1, 32'hBBBBBBBB, 1, 0, 1, 0, 0, 32'h99999999, 0));
        vt.push_back(mk("inval_won_000",       1, 32'h000, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0));

        rst         = 1'b0;
        bus.addr    = '0;
        bus.load    = 1'b0;
        bus.edit    = 1'b0;
        bus.invalid = 1'b0;
        bus.din     = '0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1;
            rst         = vt[i].rstn;
            bus.addr    = vt[i].addr;
            bus.load    = vt[i].load;
            bus.edit    = vt[i].edit;
            bus.invalid = vt[i].inv;
            bus.din     = vt[i].din;
            sb.push_back(vt[i]);
        end

        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.load    = 1'b0;
        bus.edit    = 1'b0;
        bus.invalid = 1'b0;
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        #1;
        nchk++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
